exe_hazard_forward_ctrl: RTL

- Sequencing controller for the execute-stage datapath.
- Keeps its own shadow pipeline (EXE/MEM/WB slots) of decode information.
- Drives the 2-bit forwarding selects of the execute-stage operand muxes, detects load-use hazards, and generates a pipeline-wide freeze while a multi-cycle data-memory access in MEM completes.
- Sits beside the ID/EXE/MEM/WB pipeline registers and drives their stall/freeze/bubble controls.

---
 rtl/exe_hazard_forward_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exe_hazard_forward_ctrl.sv
// Execute-stage sequencing controller: shadow EXE/MEM/WB slots, operand forwarding
// selects, load-use / RAW stall detection and the multi-cycle memory freeze.
module exe_hazard_forward_ctrl #(
    parameter int MEM_LATENCY = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fwd_en,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [3:0]           id_src1,
    input  logic [3:0]           id_src2,
    input  logic                 id_use_src1,
    input  logic                 id_use_src2,
    input  logic [3:0]           id_dest,
    input  logic                 id_wb_en,
    input  logic                 id_mem_r_en,
    input  logic                 id_mem_w_en,
    output logic [1:0]           Forwarding_Sel1,
    output logic [1:0]           Forwarding_Sel2,
    output logic                 hazard_stall,
    output logic                 freeze,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_r;
        logic       mem_w;
    } slot_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

    // cnt_q holds the number of WAIT cycles still to come after the current one.
    localparam int CW = (MEM_LATENCY > 3) ? $clog2(MEM_LATENCY - 2) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LATENCY > 3) ? (MEM_LATENCY - 3) : 0);

    slot_t                exe_q, mem_q, wb_q, exe_d;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic                 mem_op, hit_exe, hit_mem, raw_fwd, raw_nofwd;
    logic [1:0][3:0]      op_src;
    logic [1:0]           op_use;
    logic [1:0][1:0]      op_sel;
    logic                 unused_slot_bits;

    assign mem_op = mem_q.valid && (mem_q.mem_r || mem_q.mem_w);

    // Forwarding selects; MEM is tried before WB and never forwards a load.
    assign op_src = {exe_q.src2, exe_q.src1};
    assign op_use = {exe_q.use2, exe_q.use1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [1:0] sel;
            always_comb begin
                sel = 2'b00;
                if (fwd_en && op_use[gi]) begin
                    if (mem_q.valid && mem_q.wb_en && !mem_q.mem_r && mem_q.dest == op_src[gi])
                        sel = 2'b01;
                    else if (wb_q.valid && wb_q.wb_en && wb_q.dest == op_src[gi])
                        sel = 2'b10;
                end
            end
            assign op_sel[gi] = sel;
        end
    endgenerate

    assign Forwarding_Sel1 = op_sel[0];
    assign Forwarding_Sel2 = op_sel[1];

    assign hit_exe = (id_use_src1 && id_src1 == exe_q.dest) || (id_use_src2 && id_src2 == exe_q.dest);
    assign hit_mem = (id_use_src1 && id_src1 == mem_q.dest) || (id_use_src2 && id_src2 == mem_q.dest);
    assign raw_fwd   = id_valid && exe_q.valid && exe_q.mem_r && hit_exe;
    assign raw_nofwd = id_valid && ((exe_q.valid && exe_q.wb_en && hit_exe) ||
                                    (mem_q.valid && mem_q.wb_en && hit_mem));
    assign hazard_stall = (fwd_en ? raw_fwd : raw_nofwd) && !freeze && !flush;

    always_comb begin
        exe_d = '0;
        if (id_valid && !hazard_stall && !flush) begin
            exe_d.valid = 1'b1;
            exe_d.src1  = id_src1;
            exe_d.src2  = id_src2;
            exe_d.use1  = id_use_src1;
            exe_d.use2  = id_use_src2;
            exe_d.dest  = id_dest;
            exe_d.wb_en = id_wb_en;
            exe_d.mem_r = id_mem_r_en;
            exe_d.mem_w = id_mem_w_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= exe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && MEM_LATENCY > 1) begin
                    if (MEM_LATENCY == 2) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RELEASE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        freeze = 1'b0;
        case (state_q)
            S_IDLE:  freeze = mem_op && (MEM_LATENCY > 1);
            S_WAIT:  freeze = 1'b1;
            default: freeze = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count_q <= '0;
        else if ((hazard_stall || freeze) && stall_count_q != '1)
            stall_count_q <= stall_count_q + CNT_WIDTH'(1);
    end

    assign stall_count = stall_count_q;

    // Slot fields carried for completeness but not consumed downstream of their stage.
    assign unused_slot_bits = ^{exe_q.mem_w, mem_q.src1, mem_q.src2, mem_q.use1, mem_q.use2,
                                wb_q.src1, wb_q.src2, wb_q.use1, wb_q.use2, wb_q.mem_r, wb_q.mem_w};

endmodule
